// File: rtl/matdet_sched.sv
// rtl/matdet_sched.sv - round-robin scheduler sharing one multicycle determinant datapath
// Optional result cache enabled by defining MATDET_SCHED_CACHE_EN.
module matdet_sched #(
  parameter int DATA_WIDTH    = 8,
  parameter int MATRIX_SIZE   = 100,
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int ID_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ-1:0]                        req,
  input  logic [NUM_REQ*MATRIX_SIZE*DATA_WIDTH-1:0] mat_in,
  output logic [NUM_REQ-1:0]                        ack,
  output logic [DATA_WIDTH-1:0]                     det,
  output logic                                      det_valid,
  output logic [ID_WIDTH-1:0]                       det_id,
  output logic                                      busy,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0]         dp_a,
  input  logic [DATA_WIDTH-1:0]                     dp_det
);
  localparam int MAT_W = MATRIX_SIZE * DATA_WIDTH;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ID_WIDTH-1:0] PTR_RESET = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [ID_WIDTH:0]   NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t              state, state_nx;
  logic [MAT_W-1:0]    dp_a_nx;
  logic [DATA_WIDTH-1:0] det_nx;
  logic [ID_WIDTH-1:0] det_id_nx;
  logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;

  logic [ID_WIDTH:0]     ptr_next;
  logic [2*NUM_REQ-1:0]  req_dbl;
  logic [NUM_REQ-1:0]    req_rot;
  logic [ID_WIDTH:0]     rot_off;
  logic [ID_WIDTH:0]     grant_sum;
  logic                  grant_any;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [MAT_W-1:0]      win_mat;

`ifdef MATDET_SCHED_CACHE_EN
  logic cache_valid, cache_valid_nx;
  logic cache_hit;
`endif

  // Rotate requests so bit 0 is the requester just after the last winner.
  always_comb begin
    ptr_next  = {1'b0, rr_ptr} + 1'b1;
    req_dbl   = {req, req};
    req_rot   = NUM_REQ'(req_dbl >> ptr_next);
    grant_any = |req_rot;
    rot_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) rot_off = (ID_WIDTH+1)'(k);
    end
    grant_sum = ptr_next + rot_off;
    if (grant_sum >= NUM_REQ_W) grant_sum = grant_sum - NUM_REQ_W;
    grant_id = grant_sum[ID_WIDTH-1:0];
  end

  always_comb begin
    win_mat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) win_mat = mat_in[i*MAT_W +: MAT_W];
    end
  end

`ifdef MATDET_SCHED_CACHE_EN
  // dp_a still holds the last computed matrix, so it doubles as the cache tag.
  assign cache_hit = cache_valid && (win_mat == dp_a);
`endif

  always_comb begin
    state_nx  = state;
    dp_a_nx   = dp_a;
    det_nx    = det;
    det_id_nx = det_id;
    rr_ptr_nx = rr_ptr;
    cnt_nx    = cnt;
`ifdef MATDET_SCHED_CACHE_EN
    cache_valid_nx = cache_valid;
`endif
    case (state)
      IDLE: begin
        if (grant_any) begin
          det_id_nx = grant_id;
          rr_ptr_nx = grant_id;
`ifdef MATDET_SCHED_CACHE_EN
          if (cache_hit) begin
            state_nx = DONE;
          end else begin
            dp_a_nx  = win_mat;
            cnt_nx   = CNT_LOAD;
            state_nx = SETTLE;
          end
`else
          dp_a_nx  = win_mat;
          cnt_nx   = CNT_LOAD;
          state_nx = SETTLE;
`endif
        end
      end
      SETTLE: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else begin
          det_nx   = dp_det;
          state_nx = DONE;
`ifdef MATDET_SCHED_CACHE_EN
          cache_valid_nx = 1'b1;
`endif
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    det_valid = (state == DONE);
    ack       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = (state == DONE) && (det_id == ID_WIDTH'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dp_a   <= '0;
      det    <= '0;
      det_id <= '0;
      rr_ptr <= PTR_RESET;
      cnt    <= '0;
`ifdef MATDET_SCHED_CACHE_EN
      cache_valid <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      dp_a   <= dp_a_nx;
      det    <= det_nx;
      det_id <= det_id_nx;
      rr_ptr <= rr_ptr_nx;
      cnt    <= cnt_nx;
`ifdef MATDET_SCHED_CACHE_EN
      cache_valid <= cache_valid_nx;
`endif
    end
  end

endmodule

// File: tb/tb_matdet_sched.sv
// tb/tb_matdet_sched.sv - scoreboard bench for matdet_sched with a 10x10 determinant datapath model
`timescale 1ns/1ps
module tb_matdet_sched;
  localparam int DW    = 8;
  localparam int N     = 10;
  localparam int MS    = N * N;
  localparam int NR    = 4;
  localparam int S     = 4;
  localparam int IW    = 2;
  localparam int MAT_W = MS * DW;
`ifdef MATDET_SCHED_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = S + 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*MAT_W-1:0] mat_in = '0;
  logic [NR-1:0]     ack;
  logic [DW-1:0]     det;
  logic              det_valid;
  logic [IW-1:0]     det_id;
  logic              busy;
  logic [MAT_W-1:0]  dp_a;
  logic [DW-1:0]     dp_det;

  matdet_sched #(
    .DATA_WIDTH(DW), .MATRIX_SIZE(MS), .NUM_REQ(NR), .SETTLE_CYCLES(S), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .mat_in(mat_in), .ack(ack), .det(det),
    .det_valid(det_valid), .det_id(det_id), .busy(busy), .dp_a(dp_a), .dp_det(dp_det)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Division-free (Bird) determinant, valid over integers mod 2^DW.
  function automatic logic [DW-1:0] model_det(input logic [MAT_W-1:0] flat);
    logic [DW-1:0] a [N][N];
    logic [DW-1:0] x [N][N];
    logic [DW-1:0] mu[N][N];
    logic [DW-1:0] acc;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a[i][j] = flat[(i*N+j)*DW +: DW];
        x[i][j] = a[i][j];
      end
    for (int it = 1; it < N; it++) begin
      for (int i = 0; i < N; i++) begin
        acc = '0;
        for (int k = i + 1; k < N; k++) acc = acc + x[k][k];
        for (int j = 0; j < N; j++)
          mu[i][j] = (j < i) ? '0 : ((j == i) ? DW'(0) - acc : x[i][j]);
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc = '0;
          for (int k = 0; k < N; k++) acc = acc + DW'(mu[i][k] * a[k][j]);
          x[i][j] = acc;
        end
    end
    return ((N % 2) == 0) ? DW'(0) - x[0][0] : x[0][0];
  endfunction

  always_comb dp_det = model_det(dp_a);

  function automatic logic [MAT_W-1:0] diag_mat(input logic [DW-1:0] d0, input logic [DW-1:0] dr);
    logic [MAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[(i*N+i)*DW +: DW] = (i == 0) ? d0 : dr;
    return m;
  endfunction

  function automatic logic [MAT_W-1:0] swap_mat();
    logic [MAT_W-1:0] m;
    int r;
    m = '0;
    for (int i = 0; i < N; i++) begin
      r = (i == 0) ? 1 : ((i == 1) ? 0 : i);
      m[(r*N+i)*DW +: DW] = 8'd1;
    end
    return m;
  endfunction

  function automatic logic [MAT_W-1:0] tri_mat();
    logic [MAT_W-1:0] m;
    m = diag_mat(8'd2, 8'd1);
    m[(1*N+1)*DW +: DW] = 8'd2;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++) m[(i*N+j)*DW +: DW] = DW'(i*7 + j + 1);
    return m;
  endfunction

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { int id; int det; int cyc; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [NR-1:0] drop_after_ack = '1;

  always @(negedge clk) begin
    if (det_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("det_id", 64'(det_id), 64'(mon_e.id));
        check("det", 64'(det), 64'(mon_e.det));
        check("valid_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("ack_onehot", 64'(ack), 64'(1) << mon_e.id);
      end
    end else if (ack != '0) begin
      check("ack_without_valid", 64'(ack), 64'd0);
    end
  end

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NR; i++)
      if (ack[i] && drop_after_ack[i]) req[i] = 1'b0;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_det"}, 64'(det), 64'd0);
    check({tag, "_det_id"}, 64'(det_id), 64'd0);
    check({tag, "_det_valid"}, 64'(det_valid), 64'd0);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_dp_a_zero"}, 64'(dp_a == '0), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check_zero_outputs("rst");
  endtask

  int c0, c1;

  initial begin
    // Identity on requester 0, busy window and single-job latency.
    do_reset();
    drop_after_ack = '1;
    mat_in[0 +: MAT_W] = diag_mat(8'd1, 8'd1);
    c0 = cyc;
    req[0] = 1'b1;
    sb.push_back('{0, 1, c0 + S + 1});
    check("busy_c0", 64'(busy), 64'd0);
    for (int k = 1; k <= S + 3; k++) begin
      step();
      check("busy_window", 64'(busy), 64'((k >= 1) && (k <= S + 1)));
    end
    wait_empty(20);

    // All four requesting at once, each dropping after its ack.
    do_reset();
    mat_in[0*MAT_W +: MAT_W] = diag_mat(8'd1, 8'd1);
    mat_in[1*MAT_W +: MAT_W] = diag_mat(8'd3, 8'd1);
    mat_in[2*MAT_W +: MAT_W] = swap_mat();
    mat_in[3*MAT_W +: MAT_W] = tri_mat();
    c0 = cyc;
    req = 4'b1111;
    sb.push_back('{0, 8'h01, c0 + 5});
    sb.push_back('{1, 8'h03, c0 + 11});
    sb.push_back('{2, 8'hff, c0 + 17});
    sb.push_back('{3, 8'h04, c0 + 23});
    wait_empty(60);

    // Requesters 0 and 2 keep requesting: strict alternation.
    do_reset();
    drop_after_ack = 4'b1010;
    c0 = cyc;
    req = 4'b0101;
    for (int k = 0; k < 6; k++)
      sb.push_back('{(k % 2) * 2, ((k % 2) == 0) ? 8'h01 : 8'hff, c0 + 5 + 6 * k});
    step_to(c0 + 35);
    req = '0;
    wait_empty(10);
    for (int k = 0; k < 8; k++) step();
    drop_after_ack = '1;

    // diag(2) wraps to zero; mat_in change mid-job must not leak in.
    do_reset();
    mat_in[1*MAT_W +: MAT_W] = diag_mat(8'd2, 8'd2);
    c0 = cyc;
    req[1] = 1'b1;
    sb.push_back('{1, 8'h00, c0 + 5});
    step_to(c0 + 2);
    mat_in[1*MAT_W +: MAT_W] = diag_mat(8'd1, 8'd1);
    wait_empty(20);
    step();
    step();
    mat_in[1*MAT_W +: MAT_W] = diag_mat(8'd3, 8'd1);
    c1 = cyc;
    req[1] = 1'b1;
    sb.push_back('{1, 8'h03, c1 + 5});
    wait_empty(20);
    step();

    // Reset in the middle of a requester-3 job; req stays high across it.
    mat_in[3*MAT_W +: MAT_W] = tri_mat();
    c0 = cyc;
    req[3] = 1'b1;
    step_to(c0 + 3);
    check("busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_zero_outputs("midjob_rst");
    sb.push_back('{3, 8'h04, c0 + 9});
    wait_empty(20);

    // Same matrix twice from requester 1: cache hit latency when enabled.
    do_reset();
    mat_in[1*MAT_W +: MAT_W] = diag_mat(8'd3, 8'd1);
    c0 = cyc;
    req[1] = 1'b1;
    sb.push_back('{1, 8'h03, c0 + 5});
    wait_empty(20);
    step_to(c0 + 7);
    c1 = cyc;
    req[1] = 1'b1;
    sb.push_back('{1, 8'h03, c1 + HIT_LAT});
    wait_empty(20);
    check("dp_a_hold", 64'(dp_a == diag_mat(8'd3, 8'd1)), 64'd1);
    for (int k = 0; k < 4; k++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matdet_sched.md
Name: matdet_sched

Overview:
- Round-robin scheduler that shares one combinational determinant datapath (matdet10 or smaller, with its mul/add/sub tree) among NUM_REQ requesters.
- Latches the granted requester's matrix into a register that drives the datapath.
- Holds that register for SETTLE_CYCLES, so the deep combinational tree runs as a constrained multicycle path.
- Captures the result and returns it with a one-cycle valid/ack pulse tagged with the requester id.

Parameters:
- DATA_WIDTH, 8, element and determinant width; arithmetic wraps modulo 2^DATA_WIDTH.
- MATRIX_SIZE, 100, element count per matrix (flat bus, element i at bits [i*DATA_WIDTH +: DATA_WIDTH]).
- NUM_REQ, 4, number of requesters, legal range 2..16.
- SETTLE_CYCLES, 4, cycles dp_a is held before dp_det is sampled; must be >=1.
- ID_WIDTH, $clog2(NUM_REQ), width of det_id.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_REQ  level request per requester; held until its ack
- mat_in  in  NUM_REQ*MATRIX_SIZE*DATA_WIDTH  requester i matrix at slice i; stable while req[i]=1
- ack  out  NUM_REQ  one-cycle pulse to the requester being served
- det  out  DATA_WIDTH  captured determinant, held until next capture
- det_valid  out  1  one-cycle pulse when det updates
- det_id  out  ID_WIDTH  requester index of current det
- busy  out  1  high in SETTLE and DONE
- dp_a  out  MATRIX_SIZE*DATA_WIDTH  registered matrix to shared datapath
- dp_det  in  DATA_WIDTH  datapath result (combinational from dp_a)

Behaviour:
- All state updates on posedge clk. Reset is synchronous and active-high.
- rst=1 at an edge sets: state=IDLE, dp_a=0, det=0, det_id=0, det_valid=0, ack=0, busy=0, rr_ptr=NUM_REQ-1 (req[0] wins first). rst dominates every other event.
- FSM states:
  - IDLE: arbitrate. Search req from rr_ptr+1 upward, wrapping. If any req is set at the edge: dp_a<=mat_in slice of winner g; det_id<=g; rr_ptr<=g; cnt<=SETTLE_CYCLES-1; state<=SETTLE. If no req, stay in IDLE.
  - SETTLE: each edge, if cnt!=0 then cnt<=cnt-1. If cnt==0: det<=dp_det; state<=DONE. dp_a is stable for exactly SETTLE_CYCLES full cycles before sampling.
  - DONE: det_valid=1, ack[det_id]=1, busy=1 for exactly this cycle. No arbitration. Next edge goes to IDLE.
- Timing: request sampled in cycle 0 → busy cycles 1..S+1 → det_valid/ack in cycle S+1 → next arbitration in cycle S+2. Throughput is one job per S+2 cycles.
- Requester handshake: deassert req in the cycle after ack. If req is still high in IDLE, it is a new request.
- A requester may drop req before ack. The job in flight still completes and acks. That ack is ignored.
- mat_in is sampled only at the IDLE→SETTLE edge. Later changes have no effect on the job in flight.
- Simultaneous requests: one grant per IDLE cycle, strict round-robin from rr_ptr+1. A winner gets no second grant while any other req is pending.
- dp_det is passed to det unmodified. No sign or width handling in this block.
- Reset mid-SETTLE or mid-DONE: the job is discarded with no ack. A requester still holding req is re-arbitrated after reset, with req[0] first.
- det and det_id hold their last values between jobs. Only det_valid marks new data.

Optional Feature:
- Macro MATDET_SCHED_CACHE_EN (result cache).
- When defined:
  - 1-bit cache_valid (reset 0) is set at each SETTLE→DONE edge.
  - In IDLE, if cache_valid=1 and the winner's matrix equals dp_a bit-for-bit: det_id<=g; rr_ptr<=g; det keeps its value; state<=DONE directly.
  - det_valid/ack appear in cycle 1 instead of S+1.
  - dp_a is unchanged on a hit.
- When undefined: no comparator, no cache_valid; every job goes through SETTLE.

Test Plan:
- Reset, S=4, req[0]=1 with 10x10 identity on slice 0 driving a real matdet10 → busy cycles 1..5; det_valid=1, ack[0]=1, det=0x01, det_id=0 in cycle 5 only.
- req=4'b1111 held from cycle 0, each requester dropping req after its ack → det_valid in cycles 5,11,17,23 with det_id 0,1,2,3; never two ack bits at once.
- req[0] and req[2] re-asserted immediately after every ack → det_id sequence 0,2,0,2,0,2; req[0] never served twice in a row.
- req[1]=1 with diag(2,...,2) 10x10 → det=0x00 (1024 mod 256). Then diag(3,1,...,1) → det=0x03.
- rst=1 in cycle 3 of a req[3] job, released cycle 4, req[3] held → no ack before reset; all outputs 0 in cycle 4. Job re-granted in cycle 4; det_valid in cycle 9, det_id=3.
- MATDET_SCHED_CACHE_EN defined: same matrix from req[1] twice → second det_valid 1 cycle after its grant cycle with an identical det. Macro undefined → second det_valid 5 cycles after its grant cycle.
